// File: rtl/uart_pkg.sv
// Shared UART definitions, used by the transmitter and the matching receiver.
//   state_t     : frame FSM states (PARITY is only reached when
//                 UART_TX_PARITY_EN is defined)
//   DATA_BITS   : payload bits per frame
//   FRAME_BITS  : bit periods per frame, start and stop included
//   LINE_IDLE   : level of an idle serial line
//   bit_period(): clock cycles per bit from the half-bit count
// Optional feature macro: UART_TX_PARITY_EN (even parity bit after the data).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int DATA_BITS = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam logic LINE_IDLE = 1'b1;

    function automatic int bit_period(input int clk_per_half_bit);
        return 2 * clk_per_half_bit;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous circular-buffer FIFO feeding the transmitter.
//   clk, rst : clock, synchronous active-high reset (flushes contents)
//   push/din : write din when push && !full
//   pop/dout : dout shows the head entry; pop advances when !empty
//   full, empty, count : registered occupancy state (count is AW+1 bits)
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally at AW bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with an input byte FIFO.
//   clk, rst   : clock, synchronous active-high reset
//   tdata      : byte to send, accepted when tvalid && tready
//   tvalid     : tdata valid
//   tready     : FIFO not full
//   txd        : registered serial line, idle high, LSB first
//   busy       : frame in progress or bytes queued
//   fifo_count : bytes queued, excluding the one being shifted
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 5208,
    parameter int FIFO_DEPTH_LOG2  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               tdata,
    input  logic                     tvalid,
    output logic                     tready,
    output logic                     txd,
    output logic                     busy,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count
);

    localparam int BIT_CYC = bit_period(CLK_PER_HALF_BIT);
    localparam int CW      = $clog2(BIT_CYC);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic          tick;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic [7:0]    head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          load;
    logic          shift_en;
    logic          txd_nx;
`ifdef UART_TX_PARITY_EN
    logic          par;
`endif

    uart_tx_fifo #(
        .WIDTH (8),
        .AW    (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tvalid && tready),
        .din   (tdata),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tready = !fifo_full;
    assign busy   = (state != IDLE) || (fifo_count != '0);
    assign tick   = (cnt == CW'(BIT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (!fifo_empty) state_nx = START;
            START:  if (tick) state_nx = DATA;
`ifdef UART_TX_PARITY_EN
            DATA:   if (tick && bit_idx == 3'd7) state_nx = PARITY;
            PARITY: if (tick) state_nx = STOP;
`else
            DATA:   if (tick && bit_idx == 3'd7) state_nx = STOP;
`endif
            // Back-to-back frames: a queued byte starts on the stop edge.
            STOP:   if (tick) state_nx = fifo_empty ? IDLE : START;
            default: state_nx = IDLE;
        endcase
    end

    // txd_nx is the value the line takes on the coming edge, so every
    // change lands exactly on a bit boundary.
    always_comb begin
        pop      = 1'b0;
        load     = 1'b0;
        shift_en = 1'b0;
        txd_nx   = txd;
        case (state)
            IDLE: begin
                txd_nx = LINE_IDLE;
                if (!fifo_empty) begin
                    pop    = 1'b1;
                    load   = 1'b1;
                    txd_nx = 1'b0;
                end
            end
            START: if (tick) txd_nx = shift[0];
            DATA: if (tick) begin
                if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    txd_nx = par;
`else
                    txd_nx = LINE_IDLE;
`endif
                end else begin
                    shift_en = 1'b1;
                    txd_nx   = shift[1];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (tick) txd_nx = LINE_IDLE;
`endif
            STOP: if (tick) begin
                if (!fifo_empty) begin
                    pop    = 1'b1;
                    load   = 1'b1;
                    txd_nx = 1'b0;
                end else begin
                    txd_nx = LINE_IDLE;
                end
            end
            default: txd_nx = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            txd     <= LINE_IDLE;
            cnt     <= '0;
            shift   <= '0;
            bit_idx <= '0;
        end else begin
            txd <= txd_nx;
            if (load || state == IDLE || tick) cnt <= '0;
            else                               cnt <= cnt + 1'b1;
            if (load) begin
                shift   <= head;
                bit_idx <= '0;
            end else if (shift_en) begin
                shift   <= shift >> 1;
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)       par <= 1'b0;
        else if (load) par <= ^head;
    end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx (CLK_PER_HALF_BIT=4, FIFO_DEPTH_LOG2=2).
// A serial-line monitor decodes every frame on txd and compares it with a
// scoreboard filled as bytes are accepted; directed steps check exact
// per-cycle waveforms, handshake back-pressure and reset behaviour.
module tb_uart_tx;

    localparam int HALF = 4;
    localparam int AW   = 2;
    localparam int BITC = 2 * HALF;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    tdata = 8'h00;
    logic          tvalid = 1'b0;
    logic          tready;
    logic          txd;
    logic          busy;
    logic [AW:0]   fifo_count;

    int            vectors = 0;
    int            miscompares = 0;
    logic          mon_en = 1'b1;
    logic [7:0]    sb [$];

    uart_tx #(
        .CLK_PER_HALF_BIT (HALF),
        .FIFO_DEPTH_LOG2  (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tdata      (tdata),
        .tvalid     (tvalid),
        .tready     (tready),
        .txd        (txd),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level for frame bit k of byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Present b, wait for tready, return after the accepting edge.
    task automatic push_byte(input logic [7:0] b, output int low);
        @(negedge clk);
        tdata  = b;
        tvalid = 1'b1;
        low    = 0;
        while (!tready && low < 2000) begin
            low++;
            @(negedge clk);
        end
        if (low >= 2000) check("push_timeout", 32'(tready), 32'd1);
        @(posedge clk);
        if (mon_en) sb.push_back(b);
        #1 tvalid = 1'b0;
    endtask

    // Cycle-exact comparison of one frame, starting at the negedge after
    // the edge that drives the start bit. pbit returns the mid parity sample.
    task automatic check_frame(input logic [7:0] b, output logic pbit);
        pbit = 1'b0;
        for (int k = 0; k < NB * BITC; k++) begin
            @(negedge clk);
            check($sformatf("wave_%02h_k%0d", b, k), 32'(txd), 32'(exp_bit(b, k / BITC)));
            if (k == 9 * BITC + HALF) pbit = txd;
        end
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        @(negedge clk);
        while ((busy || sb.size() != 0) && n < bound) begin
            n++;
            @(negedge clk);
        end
        check("drain_done", 32'(n < bound), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    // Line monitor acting as the receiver: mid-bit sampling of each frame.
    initial begin
        logic [7:0] d;
        forever begin
            @(negedge clk);
            if (mon_en && !rst && txd == 1'b0) begin
                repeat (HALF - 1) @(negedge clk);
                check("mon_start", 32'(txd), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BITC) @(negedge clk);
                    d[i] = txd;
                end
`ifdef UART_TX_PARITY_EN
                repeat (BITC) @(negedge clk);
                check("mon_parity", 32'(txd), 32'(^d));
`endif
                repeat (BITC) @(negedge clk);
                check("mon_stop", 32'(txd), 32'd1);
                if (sb.size() == 0) check("mon_unexpected_frame", 32'(d), 32'hFFFF_FFFF);
                else check("mon_byte", 32'(d), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        int   low;
        logic pb;
        logic any_low;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_tready", 32'(tready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single byte, exact waveform and busy drop
        push_byte(8'hA5, low);
        @(negedge clk);
        check("a5_txd_pre", 32'(txd), 32'd1);
        check("a5_count", 32'(fifo_count), 32'd1);
        check("a5_busy", 32'(busy), 32'd1);
        check_frame(8'hA5, pb);
        check("a5_busy_last", 32'(busy), 32'd1);
        @(negedge clk);
        check("a5_busy_drop", 32'(busy), 32'd0);
        check("a5_txd_idle", 32'(txd), 32'd1);
        repeat (10) @(negedge clk);

        // Back-to-back frames, no idle gap
        push_byte(8'h00, low);
        push_byte(8'hFF, low);
        check_frame(8'h00, pb);
        check_frame(8'hFF, pb);
        @(negedge clk);
        check("b2b_busy_drop", 32'(busy), 32'd0);
        wait_idle(100);

        // Full FIFO with back-pressure
        push_byte(8'h11, low);
        push_byte(8'h22, low);
        push_byte(8'h33, low);
        push_byte(8'h44, low);
        push_byte(8'h55, low);
        check("full_low_b4", 32'(low), 32'd0);
        check("full_count", 32'(fifo_count), 32'd4);
        check("full_tready", 32'(tready), 32'd0);
        push_byte(8'h66, low);
        check("full_wait_cycles", 32'(low), 32'(NB * BITC - 3));
        check("full_count_after", 32'(fifo_count), 32'd4);
        wait_idle(2000);

        // Loopback through the line monitor
        push_byte(8'h00, low);
        push_byte(8'h55, low);
        push_byte(8'hFF, low);
        wait_idle(1000);

        // Reset during data bit 3 of 0x3C
        mon_en = 1'b0;
        push_byte(8'h3C, low);
        repeat (3 + 4 * BITC + HALF - 1) @(negedge clk);
        check("rst_mid_bit3", 32'(txd), 32'(exp_bit(8'h3C, 4)));
        check("rst_mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_txd", 32'(txd), 32'd1);
        check("rst_mid_busy0", 32'(busy), 32'd0);
        check("rst_mid_count", 32'(fifo_count), 32'd0);
        check("rst_mid_tready", 32'(tready), 32'd1);
        rst = 1'b0;
        any_low = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txd == 1'b0 || busy) any_low = 1'b1;
        end
        check("rst_no_frame", 32'(any_low), 32'd0);
        mon_en = 1'b1;

`ifdef UART_TX_PARITY_EN
        push_byte(8'h07, low);
        @(negedge clk);
        check_frame(8'h07, pb);
        check("parity_07", 32'(pb), 32'd1);
        @(negedge clk);
        check("parity_07_len", 32'(busy), 32'd0);
        push_byte(8'h03, low);
        @(negedge clk);
        check_frame(8'h03, pb);
        check("parity_03", 32'(pb), 32'd0);
        wait_idle(200);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
